// File: rtl/alu_pipe_if.sv
// Handshake and data bundle for alu_pipe: request side (valid/ready, opcode, operands)
// and result side (valid/ready, result, flags).
interface alu_pipe_if #(
    parameter int unsigned DW = 8
);
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    operation;
    logic [DW-1:0] input1;
    logic [DW-1:0] input2;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] Output;
    logic          Zero;
    logic          Carry;
    logic          Negative;
    logic          Illegal;

    // master issues operations and consumes results
    modport master (
        output in_valid, operation, input1, input2, out_ready,
        input  in_ready, out_valid, Output, Zero, Carry, Negative, Illegal
    );

    modport slave (
        input  in_valid, operation, input1, input2, out_ready,
        output in_ready, out_valid, Output, Zero, Carry, Negative, Illegal
    );
endinterface

// File: rtl/alu_pipe.sv
// Pipelined ALU: 4-bit opcode, carry/negative/illegal flags, STAGES register stages with
// valid/ready on both sides and bubble-collapsing stall logic.
module alu_pipe #(
    parameter int unsigned DW     = 8,
    parameter int unsigned STAGES = 2
) (
    input logic       CLK,
    input logic       Reset,
    alu_pipe_if.slave bus
);
    localparam int unsigned SHW = $clog2(DW);
    localparam logic [DW-1:0]  DW_B = DW'(DW);
    localparam logic [SHW:0]   DW_R = (SHW + 1)'(DW);
    localparam logic [DW:0]    ONE  = (DW + 1)'(1);

    typedef struct packed {
        logic [DW-1:0] res;
        logic          carry;
        logic          ill;
    } stage_t;

    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW:0]   a_x;
    logic [DW:0]   b_x;
    logic [SHW:0]  rot;
    logic signed [DW:0] asr_x;

    logic [DW-1:0] alu_res;
    logic          alu_c;
    logic          alu_ill;

    stage_t st_q  [STAGES];
    stage_t st_in [STAGES];
    logic   v_q   [STAGES];
    logic   v_in  [STAGES];
    logic   load  [STAGES];

    assign a     = bus.input1;
    assign b     = bus.input2;
    assign a_x   = {1'b0, a};
    assign b_x   = {1'b0, b};
    assign rot   = {1'b0, b[SHW-1:0]};
    // Appended guard bit catches the last bit shifted out on the right
    assign asr_x = $signed({a, 1'b0}) >>> b;

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_ill = 1'b0;
        case (bus.operation)
            4'd0:  {alu_c, alu_res} = a_x + ONE;
            4'd1:  {alu_c, alu_res} = a_x - ONE;
            4'd2:  alu_res = a ^ b;
            4'd3:  alu_res = {{(DW - 1){1'b0}}, ^a};
            4'd4:  {alu_c, alu_res} = a_x << b;
            4'd5:  {alu_res, alu_c} = {a, 1'b0} >> b;
            4'd6:  alu_res = a & b;
            4'd7:  alu_res = a;
            4'd8:  {alu_c, alu_res} = a_x + b_x;
            4'd9:  {alu_c, alu_res} = a_x - b_x;
            4'd10: alu_res = a | b;
            4'd11: begin
                {alu_res, alu_c} = asr_x;
                if (b > DW_B) alu_c = 1'b0;
            end
            4'd12: alu_res = (a << rot) | (a >> (DW_R - rot));
            4'd13: alu_res = (a >> rot) | (a << (DW_R - rot));
            default: begin
                alu_res = a;
                alu_ill = 1'b1;
            end
        endcase
    end

    // A stage can load if it or any stage downstream of it has a free slot this cycle
    always_comb begin : ready_chain
        logic acc;
        acc = bus.out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc     = acc | ~v_q[k];
            load[k] = acc;
        end
    end

    always_comb begin
        v_in[0]  = bus.in_valid;
        st_in[0] = '{res: alu_res, carry: alu_c, ill: alu_ill};
        for (int k = 1; k < STAGES; k++) begin
            v_in[k]  = v_q[k-1];
            st_in[k] = st_q[k-1];
        end
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k]  <= 1'b0;
                st_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (load[k]) begin
                    v_q[k] <= v_in[k];
                    if (v_in[k]) st_q[k] <= st_in[k];
                end
            end
        end
    end

    assign bus.in_ready  = load[0];
    assign bus.out_valid = v_q[STAGES-1];
    assign bus.Output    = st_q[STAGES-1].res;
    assign bus.Carry     = st_q[STAGES-1].carry;
    assign bus.Illegal   = st_q[STAGES-1].ill;
    assign bus.Zero      = ~|st_q[STAGES-1].res;
    assign bus.Negative  = st_q[STAGES-1].res[DW-1];
endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe at DW=8, STAGES=2: single ops with hand-computed results,
// a stalled 8-op stream, mid-stream reset and illegal opcodes.
module tb_alu_pipe;
    localparam int unsigned DW     = 8;
    localparam int unsigned STAGES = 2;

    logic CLK = 1'b0;
    logic Reset;
    int   n_asserts = 0;
    int   n_fail    = 0;

    alu_pipe_if #(.DW(DW)) bus ();

    alu_pipe #(.DW(DW), .STAGES(STAGES)) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                          input logic [7:0] b, input logic [7:0] exp, input logic ec,
                          input logic ei);
        int lat;
        @(negedge CLK);
        bus.in_valid  = 1'b1;
        bus.operation = op;
        bus.input1    = a;
        bus.input2    = b;
        bus.out_ready = 1'b1;
        #1 check({tag, "_in_ready"}, bus.in_ready, 1);
        @(posedge CLK);
        lat = 0;
        do begin
            @(negedge CLK);
            bus.in_valid = 1'b0;
            bus.input1   = ~a;
            lat++;
        end while (!bus.out_valid && lat < 20);
        check({tag, "_latency"}, lat, STAGES);
        check({tag, "_out"}, bus.Output, exp);
        check({tag, "_carry"}, bus.Carry, ec);
        check({tag, "_zero"}, bus.Zero, exp == 8'h00);
        check({tag, "_neg"}, bus.Negative, exp[7]);
        check({tag, "_illegal"}, bus.Illegal, ei);
    endtask

    logic [3:0] s_op  [8];
    logic [7:0] s_a   [8];
    logic [7:0] s_b   [8];
    logic [7:0] s_exp [8];

    initial begin
        int   sent;
        int   recv;
        logic held;
        logic [7:0] held_val;

        s_op[0] = 4'd8;  s_a[0] = 8'h01; s_b[0] = 8'h02; s_exp[0] = 8'h03;
        s_op[1] = 4'd9;  s_a[1] = 8'h10; s_b[1] = 8'h01; s_exp[1] = 8'h0F;
        s_op[2] = 4'd2;  s_a[2] = 8'hAA; s_b[2] = 8'hFF; s_exp[2] = 8'h55;
        s_op[3] = 4'd10; s_a[3] = 8'hA0; s_b[3] = 8'h05; s_exp[3] = 8'hA5;
        s_op[4] = 4'd6;  s_a[4] = 8'hF0; s_b[4] = 8'h3C; s_exp[4] = 8'h30;
        s_op[5] = 4'd12; s_a[5] = 8'h80; s_b[5] = 8'h01; s_exp[5] = 8'h01;
        s_op[6] = 4'd13; s_a[6] = 8'h01; s_b[6] = 8'h01; s_exp[6] = 8'h80;
        s_op[7] = 4'd5;  s_a[7] = 8'hF0; s_b[7] = 8'h04; s_exp[7] = 8'h0F;

        Reset         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.operation = 4'd0;
        bus.input1    = '0;
        bus.input2    = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        Reset = 1'b0;
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_output", bus.Output, 0);
        check("rst_zero", bus.Zero, 1);
        check("rst_carry", bus.Carry, 0);
        check("rst_neg", bus.Negative, 0);
        check("rst_illegal", bus.Illegal, 0);
        check("rst_in_ready", bus.in_ready, 1);

        run_op("t1_add",      4'd8,  8'hF0, 8'h20, 8'h10, 1'b1, 1'b0);
        run_op("t2_sub_eq",   4'd9,  8'h05, 8'h05, 8'h00, 1'b0, 1'b0);
        run_op("t2_dec_zero", 4'd1,  8'h00, 8'h00, 8'hFF, 1'b1, 1'b0);
        run_op("t3_asr_big",  4'd11, 8'h80, 8'h09, 8'hFF, 1'b0, 1'b0);
        run_op("t3_shl_1",    4'd4,  8'h81, 8'h01, 8'h02, 1'b1, 1'b0);
        run_op("t3_rol_9",    4'd12, 8'h81, 8'h09, 8'h03, 1'b0, 1'b0);
        run_op("shr_dw",      4'd5,  8'h81, 8'h08, 8'h00, 1'b1, 1'b0);
        run_op("shl_dw",      4'd4,  8'h01, 8'h08, 8'h00, 1'b1, 1'b0);
        run_op("shl_dw1",     4'd4,  8'h01, 8'h09, 8'h00, 1'b0, 1'b0);
        run_op("asr_zero",    4'd11, 8'h40, 8'h00, 8'h40, 1'b0, 1'b0);
        run_op("ror_1",       4'd13, 8'h81, 8'h01, 8'hC0, 1'b0, 1'b0);
        run_op("parity",      4'd3,  8'h07, 8'h00, 8'h01, 1'b0, 1'b0);
        run_op("inc_wrap",    4'd0,  8'hFF, 8'h00, 8'h00, 1'b1, 1'b0);
        run_op("xor",         4'd2,  8'hFF, 8'h0F, 8'hF0, 1'b0, 1'b0);
        run_op("or",          4'd10, 8'h0F, 8'h30, 8'h3F, 1'b0, 1'b0);
        run_op("t6_illegal",  4'd14, 8'h3C, 8'h00, 8'h3C, 1'b0, 1'b1);
        run_op("t6_legal",    4'd7,  8'h55, 8'h00, 8'h55, 1'b0, 1'b0);
        run_op("illegal_15",  4'd15, 8'h80, 8'h11, 8'h80, 1'b0, 1'b1);

        // Stalled stream: out_ready low during loop cycles 3..6
        sent = 0;
        recv = 0;
        held = 1'b0;
        held_val = '0;
        for (int c = 0; c < 40 && recv < 8; c++) begin
            @(negedge CLK);
            bus.out_ready = !(c >= 3 && c <= 6);
            bus.in_valid  = (sent < 8);
            if (sent < 8) begin
                bus.operation = s_op[sent];
                bus.input1    = s_a[sent];
                bus.input2    = s_b[sent];
            end
            #1;
            check("t4_in_ready", bus.in_ready, bus.out_ready || ((sent - recv) < STAGES));
            if (bus.out_valid) begin
                if (held) check("t4_hold", bus.Output, held_val);
                if (bus.out_ready) begin
                    check("t4_order", bus.Output, s_exp[recv]);
                    recv++;
                end
            end
            held     = bus.out_valid && !bus.out_ready;
            held_val = bus.Output;
            if (bus.in_valid && bus.in_ready) sent++;
        end
        check("t4_count", recv, 8);
        bus.in_valid = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            #1 check("t4_no_dup", bus.out_valid, 0);
        end

        // Reset with two ops in flight
        @(negedge CLK);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.operation = 4'd8;
        bus.input1    = 8'h01;
        bus.input2    = 8'h01;
        @(negedge CLK);
        bus.input1    = 8'h02;
        bus.input2    = 8'h02;
        @(negedge CLK);
        bus.in_valid = 1'b0;
        #1 check("t5_preload", bus.out_valid, 1);
        Reset = 1'b1;
        @(negedge CLK);
        Reset = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        check("t5_out_valid", bus.out_valid, 0);
        check("t5_output", bus.Output, 0);
        check("t5_zero", bus.Zero, 1);
        check("t5_in_ready", bus.in_ready, 1);
        repeat (4) begin
            @(negedge CLK);
            #1 check("t5_no_stale", bus.out_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
